// File: rtl/skin_box_overlay.sv
// skin_box_overlay: gathers per-frame skin-pixel count and bounding box from a
// key-coloured mask stream, then outlines that box on the following frame.
module skin_box_overlay #(
    parameter logic [23:0] KEY_COLOUR = 24'hFF00FF,
    parameter logic [23:0] BOX_COLOUR = 24'h00FF00,
    parameter int          MIN_PIXELS = 64,
    parameter int          X_W        = 11,
    parameter int          Y_W        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_vid_data,
    input  logic        i_vid_hsync,
    input  logic        i_vid_vsync,
    input  logic        i_vid_VDE,
    output logic [23:0] o_vid_data,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic        o_vid_VDE,
    output logic        o_box_valid,
    output logic [19:0] o_pixel_count
);

    localparam int                CNT_W   = 20;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    // Edge-detect history
    logic vde_reg, vsync_reg;
    logic vde_fall, vsync_rise, skin;

    // Raster position of the pixel currently on the input
    logic [X_W-1:0] x_reg, x_next;
    logic [Y_W-1:0] y_reg, y_next;

    // Running statistics of the frame being received
    logic [X_W-1:0]   min_x_reg, min_x_next, max_x_reg, max_x_next;
    logic [Y_W-1:0]   min_y_reg, min_y_next, max_y_reg, max_y_next;
    logic [CNT_W-1:0] acc_count_reg, acc_count_next;

    // Box latched from the previous frame; stable for a whole frame
    logic [X_W-1:0]   bx_min_reg, bx_max_reg;
    logic [Y_W-1:0]   by_min_reg, by_max_reg;
    logic             box_valid_reg;
    logic [CNT_W-1:0] pixel_count_reg;

    logic on_col, on_row, draw;

    assign vde_fall   = vde_reg & ~i_vid_VDE;
    assign vsync_rise = i_vid_vsync & ~vsync_reg;
    // A skin pixel arriving with the frame latch is dropped: the latch wins.
    assign skin       = i_vid_VDE && (i_vid_data != KEY_COLOUR) && !vsync_rise;

    // Next-state for raster counters and the statistics accumulators
    always_comb begin
        x_next         = x_reg;
        y_next         = y_reg;
        min_x_next     = min_x_reg;
        max_x_next     = max_x_reg;
        min_y_next     = min_y_reg;
        max_y_next     = max_y_reg;
        acc_count_next = acc_count_reg;

        if (vde_fall) begin
            x_next = '0;
        end else if (i_vid_VDE && (x_reg != {X_W{1'b1}})) begin
            x_next = x_reg + 1'b1;
        end

        if (vsync_rise) begin
            y_next = '0;
        end else if (vde_fall && (y_reg != {Y_W{1'b1}})) begin
            y_next = y_reg + 1'b1;
        end

        if (vsync_rise) begin
            min_x_next     = '1;
            max_x_next     = '0;
            min_y_next     = '1;
            max_y_next     = '0;
            acc_count_next = '0;
        end else if (skin) begin
            if (x_reg < min_x_reg) min_x_next = x_reg;
            if (x_reg > max_x_reg) max_x_next = x_reg;
            if (y_reg < min_y_reg) min_y_next = y_reg;
            if (y_reg > max_y_reg) max_y_next = y_reg;
            if (acc_count_reg != {CNT_W{1'b1}}) acc_count_next = acc_count_reg + 1'b1;
        end
    end

    // Outline hit test against the latched box using the input-cycle position
    always_comb begin
        on_col = ((x_reg == bx_min_reg) || (x_reg == bx_max_reg)) &&
                 (y_reg >= by_min_reg) && (y_reg <= by_max_reg);
        on_row = ((y_reg == by_min_reg) || (y_reg == by_max_reg)) &&
                 (x_reg >= bx_min_reg) && (x_reg <= bx_max_reg);
        draw   = box_valid_reg && i_vid_VDE && (on_col || on_row);
    end

    // State update, frame latch and one-cycle registered video output
    always_ff @(posedge clk) begin
        if (rst) begin
            vde_reg         <= 1'b0;
            vsync_reg       <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            min_x_reg       <= '1;
            max_x_reg       <= '0;
            min_y_reg       <= '1;
            max_y_reg       <= '0;
            acc_count_reg   <= '0;
            bx_min_reg      <= '1;
            bx_max_reg      <= '0;
            by_min_reg      <= '1;
            by_max_reg      <= '0;
            box_valid_reg   <= 1'b0;
            pixel_count_reg <= '0;
            o_vid_data      <= '0;
            o_vid_hsync     <= 1'b0;
            o_vid_vsync     <= 1'b0;
            o_vid_VDE       <= 1'b0;
        end else begin
            vde_reg       <= i_vid_VDE;
            vsync_reg     <= i_vid_vsync;
            x_reg         <= x_next;
            y_reg         <= y_next;
            min_x_reg     <= min_x_next;
            max_x_reg     <= max_x_next;
            min_y_reg     <= min_y_next;
            max_y_reg     <= max_y_next;
            acc_count_reg <= acc_count_next;
            if (vsync_rise) begin
                bx_min_reg      <= min_x_reg;
                bx_max_reg      <= max_x_reg;
                by_min_reg      <= min_y_reg;
                by_max_reg      <= max_y_reg;
                box_valid_reg   <= (acc_count_reg >= MIN_CNT);
                pixel_count_reg <= acc_count_reg;
            end
            o_vid_data  <= draw ? BOX_COLOUR : i_vid_data;
            o_vid_hsync <= i_vid_hsync;
            o_vid_vsync <= i_vid_vsync;
            o_vid_VDE   <= i_vid_VDE;
        end
    end

    assign o_box_valid   = box_valid_reg;
    assign o_pixel_count = pixel_count_reg;

endmodule

// File: tb/tb_skin_box_overlay.sv
// tb_skin_box_overlay: random and directed frames through two instances
// (thresholds 4 and 1); a queue-based scoreboard checks every output cycle.
module tb_skin_box_overlay;

    localparam logic [23:0] KEY  = 24'hFF00FF;
    localparam logic [23:0] BOX  = 24'h00FF00;
    localparam logic [23:0] SKIN = 24'h808080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] i_data = '0;
    logic        i_hs = 1'b0, i_vs = 1'b0, i_vde = 1'b0;

    logic [23:0] a_data, b_data;
    logic        a_hs, a_vs, a_vde, a_valid, b_hs, b_vs, b_vde, b_valid;
    logic [19:0] a_count, b_count;

    always #5 clk = ~clk;

    skin_box_overlay #(.MIN_PIXELS(4)) dut4 (
        .clk(clk), .rst(rst), .i_vid_data(i_data), .i_vid_hsync(i_hs),
        .i_vid_vsync(i_vs), .i_vid_VDE(i_vde), .o_vid_data(a_data),
        .o_vid_hsync(a_hs), .o_vid_vsync(a_vs), .o_vid_VDE(a_vde),
        .o_box_valid(a_valid), .o_pixel_count(a_count)
    );

    skin_box_overlay #(.MIN_PIXELS(1)) dut1 (
        .clk(clk), .rst(rst), .i_vid_data(i_data), .i_vid_hsync(i_hs),
        .i_vid_vsync(i_vs), .i_vid_VDE(i_vde), .o_vid_data(b_data),
        .o_vid_hsync(b_hs), .o_vid_vsync(b_vs), .o_vid_VDE(b_vde),
        .o_box_valid(b_valid), .o_pixel_count(b_count)
    );

    typedef struct {
        logic [47:0] e4;
        logic [47:0] e1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: skin coordinates of the current frame, latched box state
    int sx_q[$];
    int sy_q[$];
    bit prev_vs = 1'b0;
    int m_count = 0;
    bit m_v4 = 1'b0, m_v1 = 1'b0;
    int bx0 = 2047, bx1 = 0, by0 = 1023, by1 = 0;
    int next_ybase = 0;

    function automatic logic [23:0] rnd_nonkey();
        logic [23:0] v;
        v = 24'($urandom);
        if (v == KEY) v = v ^ 24'h000001;
        return v;
    endfunction

    function automatic bit on_box(int x, int y);
        return (((x == bx0) || (x == bx1)) && (y >= by0) && (y <= by1)) ||
               (((y == by0) || (y == by1)) && (x >= bx0) && (x <= bx1));
    endfunction

    function automatic logic [23:0] pix(int mode, int x, int ln);
        case (mode)
            0: return KEY;
            1: return (x >= 2 && x <= 5 && ln >= 1 && ln <= 3) ? SKIN : KEY;
            2: return ((x == 1 && ln == 1) || (x == 4 && ln == 2) || (x == 9 && ln == 5)) ? SKIN : KEY;
            3: return (x == 7 && ln == 4) ? SKIN : KEY;
            4: return ($urandom_range(0, 3) == 0) ? rnd_nonkey() : KEY;
            5: return ((ln == 0 && x < 5) || (ln == 2 && (x == 3 || x == 4))) ? SKIN : KEY;
            default: return rnd_nonkey();
        endcase
    endfunction

    // Frame latch in model terms: count and bounding box of the collected pixels
    task automatic model_latch();
        m_count = sx_q.size();
        bx0 = 2047; bx1 = 0; by0 = 1023; by1 = 0;
        foreach (sx_q[i]) begin
            if (sx_q[i] < bx0) bx0 = sx_q[i];
            if (sx_q[i] > bx1) bx1 = sx_q[i];
            if (sy_q[i] < by0) by0 = sy_q[i];
            if (sy_q[i] > by1) by1 = sy_q[i];
        end
        m_v4 = (m_count >= 4);
        m_v1 = (m_count >= 1);
        sx_q.delete();
        sy_q.delete();
    endtask

    // Drive one input cycle and queue what both instances must output for it
    task automatic drive(input logic [23:0] d, input bit vs, input bit vde,
                         input bit r, input int x, input int y);
        logic        hs;
        logic [23:0] o4, o1;
        bit          rise, on;
        exp_t        e;
        @(negedge clk);
        hs = 1'($urandom);
        rst = r; i_data = d; i_hs = hs; i_vs = vs; i_vde = vde;
        if (r) begin
            sx_q.delete(); sy_q.delete();
            prev_vs = 1'b0; m_count = 0; m_v4 = 1'b0; m_v1 = 1'b0;
            e.e4 = '0;
            e.e1 = '0;
        end else begin
            rise = vs && !prev_vs;
            prev_vs = vs;
            on = vde && on_box(x, y);
            o4 = (on && m_v4) ? BOX : d;
            o1 = (on && m_v1) ? BOX : d;
            if (vde && d != KEY && !rise) begin
                sx_q.push_back(x);
                sy_q.push_back(y);
            end
            if (rise) model_latch();
            e.e4 = {o4, hs, vs, vde, m_v4, 20'(m_count)};
            e.e1 = {o1, hs, vs, vde, m_v1, 20'(m_count)};
        end
        exp_q.push_back(e);
    endtask

    // vs_pix puts an active BOX-coloured pixel on the vsync edge itself; it is
    // dropped, and its VDE fall bumps the next frame's first line to y=1.
    task automatic vsync_pulse(input bit vs_pix);
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && vs_pix) drive(BOX, 1'b1, 1'b1, 1'b0, 0, 0);
            else                  drive(rnd_nonkey(), 1'b1, 1'b0, 1'b0, 0, 0);
        end
        for (int i = 0; i < 2; i++) drive(rnd_nonkey(), 1'b0, 1'b0, 1'b0, 0, 0);
        next_ybase = vs_pix ? 1 : 0;
    endtask

    task automatic frame(input int w, input int h, input int mode,
                         input int rst_line, input bit vs_pix);
        int yb, yc, nb;
        yb = next_ybase;
        for (int ln = 0; ln < h; ln++) begin
            yc = (rst_line >= 0 && ln > rst_line) ? ln - rst_line - 1 : yb + ln;
            for (int xx = 0; xx < w; xx++) drive(pix(mode, xx, ln), 1'b0, 1'b1, 1'b0, xx, yc);
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++)
                drive(rnd_nonkey(), 1'b0, 1'b0, (ln == rst_line && b == 1), 0, 0);
        end
        vsync_pulse(vs_pix);
    endtask

    task automatic check_stats(input string name, input int cnt, input bit v4, input bit v1);
        checks += 3;
        if (a_count != 20'(cnt)) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, a_count, cnt);
        end
        if (a_valid != v4) begin
            errors++;
            $display("FAIL %s valid(min4): got %0b expected %0b", name, a_valid, v4);
        end
        if (b_valid != v1) begin
            errors++;
            $display("FAIL %s valid(min1): got %0b expected %0b", name, b_valid, v1);
        end
    endtask

    // Monitor: one queued expectation per clock, compared just after the edge
    initial begin
        exp_t        me;
        logic [47:0] act4, act1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                me   = exp_q.pop_front();
                act4 = {a_data, a_hs, a_vs, a_vde, a_valid, a_count};
                act1 = {b_data, b_hs, b_vs, b_vde, b_valid, b_count};
                checks += 2;
                if (act4 !== me.e4) begin
                    errors++;
                    $display("FAIL out_min4 @%0t: got %h expected %h", $time, act4, me.e4);
                end
                if (act1 !== me.e1) begin
                    errors++;
                    $display("FAIL out_min1 @%0t: got %h expected %h", $time, act1, me.e1);
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        for (int i = 0; i < 3; i++)
            drive(rnd_nonkey(), 1'($urandom), 1'($urandom), 1'b1, 0, 0);
        for (int i = 0; i < 2; i++) drive(rnd_nonkey(), 1'b0, 1'b0, 1'b0, 0, 0);
        vsync_pulse(1'b0);
        check_stats("lead_latch", 0, 1'b0, 1'b0);

        frame(16, 8, 0, -1, 1'b0);  check_stats("empty", 0, 1'b0, 1'b0);
        frame(16, 8, 6, -1, 1'b0);  check_stats("full", 128, 1'b1, 1'b1);
        frame(16, 8, 1, -1, 1'b0);  check_stats("block", 12, 1'b1, 1'b1);
        frame(16, 8, 6, -1, 1'b0);  check_stats("full2", 128, 1'b1, 1'b1);
        frame(16, 8, 2, -1, 1'b0);  check_stats("below", 3, 1'b0, 1'b1);
        frame(16, 8, 6, -1, 1'b0);  check_stats("full3", 128, 1'b1, 1'b1);
        frame(16, 8, 3, -1, 1'b0);  check_stats("single", 1, 1'b0, 1'b1);
        frame(16, 8, 6, -1, 1'b0);  check_stats("full4", 128, 1'b1, 1'b1);
        frame(16, 8, 5, 0, 1'b0);   check_stats("midreset", 2, 1'b0, 1'b1);
        frame(16, 8, 6, -1, 1'b1);
        frame(12, 6, 4, -1, 1'b0);

        for (int f = 0; f < 12; f++)
            frame($urandom_range(4, 20), $urandom_range(2, 10),
                  ($urandom_range(0, 1) == 0) ? 4 : 6, -1, ($urandom_range(0, 2) == 0));

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
